// File: rtl/sr04_ctrl.sv
// HC-SR04 measurement sequencer: trigger pulse, echo timing, cm conversion, timeouts, hold-off.
// Build option: define SR04_AVG_EN to report dist_cm as the mean of the last four valid results.
module sr04_ctrl #(
   parameter int TRIG_US     = 10,
   parameter int ECHO_TO_US  = 30000,
   parameter int MEAS_MAX_US = 25000,
   parameter int HOLDOFF_US  = 60000,
   parameter int US_PER_CM   = 58
) (
   input  logic        clk_1m,
   input  logic        rst_n,
   input  logic        meas_req,
   input  logic        auto_en,
   output logic        s1_trig,
   input  logic        s1_echo,
   output logic [9:0]  dist_cm,
   output logic [15:0] echo_us,
   output logic        dist_vld,
   output logic        dist_err,
   output logic        busy,
   output logic [2:0]  fsm_state
);

   localparam logic [15:0] TRIG_LAST    = 16'(TRIG_US - 1);
   localparam logic [15:0] ECHO_TO_LAST = 16'(ECHO_TO_US - 1);
   localparam logic [15:0] MEAS_MAX     = 16'(MEAS_MAX_US);
   localparam logic [15:0] HOLD_LAST    = 16'(HOLDOFF_US - 1);
   localparam logic [15:0] CM_LAST      = 16'(US_PER_CM - 1);
   localparam logic [15:0] SUB_START    = (US_PER_CM > 1) ? 16'd1 : 16'd0;
   localparam logic [15:0] CM_START     = (US_PER_CM > 1) ? 16'd0 : 16'd1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_TRIG      = 3'd1,
      S_WAIT_ECHO = 3'd2,
      S_MEAS      = 3'd3,
      S_HOLDOFF   = 3'd4
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        echo_m;
   logic        echo_s;
   logic        echo_d;
   logic        echo_rise;
   logic        echo_fall;
   logic [15:0] tmr;
   logic [15:0] us_cnt;
   logic [15:0] sub_cnt;
   logic [15:0] cm_cnt;
   logic [9:0]  cm_raw;
   logic [9:0]  cm_out;
   logic        ld_ok;
   logic        ld_err;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // echo_m/echo_s form the synchronizer; echo_d is the edge-detect reference copy.
   always_ff @(posedge clk_1m or negedge rst_n) begin
      if (!rst_n) begin
         echo_m <= 1'b0;
         echo_s <= 1'b0;
         echo_d <= 1'b0;
      end else begin
         echo_m <= s1_echo;
         echo_s <= echo_m;
         echo_d <= echo_s;
      end
   end

   assign echo_rise = echo_s & ~echo_d;
   assign echo_fall = ~echo_s & echo_d;

   always_ff @(posedge clk_1m or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ld_ok     = 1'b0;
      ld_err    = 1'b0;
      case (state)
         S_IDLE: begin
            if (meas_req || auto_en) state_nxt = S_TRIG;
         end
         S_TRIG: begin
            if (tmr >= TRIG_LAST) state_nxt = S_WAIT_ECHO;
         end
         S_WAIT_ECHO: begin
            // Only a fresh rising edge starts a measurement; a stale high level is ignored.
            if (echo_rise) begin
               state_nxt = S_MEAS;
            end else if (tmr >= ECHO_TO_LAST) begin
               ld_err    = 1'b1;
               state_nxt = S_HOLDOFF;
            end
         end
         S_MEAS: begin
            if (echo_fall) begin
               ld_ok     = 1'b1;
               state_nxt = S_HOLDOFF;
            end else if (us_cnt >= MEAS_MAX) begin
               ld_err    = 1'b1;
               state_nxt = S_HOLDOFF;
            end
         end
         S_HOLDOFF: begin
            if ((tmr >= HOLD_LAST) && !echo_s) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy      = (state != S_IDLE);
   assign fsm_state = state;

   // Phase timer restarts on every state change and saturates.
   always_ff @(posedge clk_1m or negedge rst_n) begin
      if (!rst_n)                  tmr <= 16'd0;
      else if (state_nxt != state) tmr <= 16'd0;
      else                         tmr <= sat_inc(tmr);
   end

   always_ff @(posedge clk_1m or negedge rst_n) begin
      if (!rst_n) s1_trig <= 1'b0;
      else        s1_trig <= (state_nxt == S_TRIG);
   end

   // The rise cycle itself is the first high cycle, so the counters start at one step.
   always_ff @(posedge clk_1m or negedge rst_n) begin
      if (!rst_n) begin
         us_cnt  <= 16'd0;
         sub_cnt <= 16'd0;
         cm_cnt  <= 16'd0;
      end else if ((state == S_WAIT_ECHO) && echo_rise) begin
         us_cnt  <= 16'd1;
         sub_cnt <= SUB_START;
         cm_cnt  <= CM_START;
      end else if ((state == S_MEAS) && echo_s) begin
         us_cnt <= sat_inc(us_cnt);
         if (sub_cnt >= CM_LAST) begin
            sub_cnt <= 16'd0;
            cm_cnt  <= sat_inc(cm_cnt);
         end else begin
            sub_cnt <= sub_cnt + 16'd1;
         end
      end
   end

   assign cm_raw = (cm_cnt > 16'd1023) ? 10'd1023 : cm_cnt[9:0];

`ifdef SR04_AVG_EN
   logic [9:0]  hist0;
   logic [9:0]  hist1;
   logic [9:0]  hist2;
   logic [2:0]  n_valid;
   logic [11:0] avg_sum;

   assign avg_sum = 12'(cm_raw) + 12'(hist0) + 12'(hist1) + 12'(hist2);
   assign cm_out  = (n_valid >= 3'd3) ? 10'(avg_sum >> 2) : cm_raw;

   // Only valid results enter the history; error results bypass it entirely.
   always_ff @(posedge clk_1m or negedge rst_n) begin
      if (!rst_n) begin
         hist0   <= 10'd0;
         hist1   <= 10'd0;
         hist2   <= 10'd0;
         n_valid <= 3'd0;
      end else if (ld_ok) begin
         hist2 <= hist1;
         hist1 <= hist0;
         hist0 <= cm_raw;
         if (n_valid != 3'd4) n_valid <= n_valid + 3'd1;
      end
   end
`else
   assign cm_out = cm_raw;
`endif

   // Result contract: dist_vld is a one-cycle strobe with no back-pressure; dist_err is
   // only ever high together with dist_vld, and dist_cm/echo_us hold until the next strobe.
   always_ff @(posedge clk_1m or negedge rst_n) begin
      if (!rst_n) begin
         dist_vld <= 1'b0;
         dist_err <= 1'b0;
         dist_cm  <= 10'd0;
         echo_us  <= 16'd0;
      end else begin
         dist_vld <= ld_ok | ld_err;
         dist_err <= ld_err;
         if (ld_err) begin
            dist_cm <= 10'd1023;
            echo_us <= 16'hFFFF;
         end else if (ld_ok) begin
            dist_cm <= cm_out;
            echo_us <= us_cnt;
         end
      end
   end

endmodule

// File: tb/tb_sr04_ctrl.sv
// Self-checking bench for sr04_ctrl with a behavioural sensor model and a distance reference model.
`timescale 1ns/1ps
module tb_sr04_ctrl;

   localparam int TRIG     = 10;
   localparam int ECHO_TO  = 300;
   localparam int MEAS_MAX = 2500;
   localparam int HOLD     = 200;
   localparam int UPC      = 58;

   logic        clk_1m   = 1'b0;
   logic        rst_n    = 1'b0;
   logic        meas_req = 1'b0;
   logic        auto_en  = 1'b0;
   logic        s1_echo  = 1'b0;
   logic        s1_trig;
   logic [9:0]  dist_cm;
   logic [15:0] echo_us;
   logic        dist_vld;
   logic        dist_err;
   logic        busy;
   logic [2:0]  fsm_state;

   int checks = 0;
   int errors = 0;

   // expected history of valid distances, used by the averaging reference
   logic [9:0] hist_q[$];

   int          r_trig_w;
   int          r_n_vld;
   int          r_t_vld;
   int          r_t_idle;
   logic [9:0]  r_cm;
   logic [15:0] r_us;
   logic        r_err;

   sr04_ctrl #(
      .TRIG_US     (TRIG),
      .ECHO_TO_US  (ECHO_TO),
      .MEAS_MAX_US (MEAS_MAX),
      .HOLDOFF_US  (HOLD),
      .US_PER_CM   (UPC)
   ) dut (
      .clk_1m    (clk_1m),
      .rst_n     (rst_n),
      .meas_req  (meas_req),
      .auto_en   (auto_en),
      .s1_trig   (s1_trig),
      .s1_echo   (s1_echo),
      .dist_cm   (dist_cm),
      .echo_us   (echo_us),
      .dist_vld  (dist_vld),
      .dist_err  (dist_err),
      .busy      (busy),
      .fsm_state (fsm_state)
   );

   always #5 clk_1m = ~clk_1m;

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
      checks++;
      assert (obs >= lo && obs <= hi) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   // Distance reference: integer cm = width / US_PER_CM, optionally averaged over 4 valid results.
   function automatic logic [9:0] model_cm(input int width);
      int raw;
      int sum;
      raw = width / UPC;
      if (raw > 1023) raw = 1023;
      sum = 0;
`ifdef SR04_AVG_EN
      hist_q.push_back(10'(raw));
      if (hist_q.size() > 4) void'(hist_q.pop_front());
      if (hist_q.size() == 4) begin
         foreach (hist_q[i]) sum += int'(hist_q[i]);
         return 10'(sum / 4);
      end
`endif
      return 10'(raw + sum);
   endfunction

   task automatic pulse_req(input string tag);
      @(negedge clk_1m);
      meas_req = 1'b1;
      @(negedge clk_1m);
      meas_req = 1'b0;
      chk({tag, "_trig_next"}, 32'(s1_trig), 32'd1);
      chk({tag, "_busy_next"}, 32'(busy), 32'd1);
   endtask

   // Sensor model: waits for the trigger, then plays an echo waveform relative to the trigger
   // fall (iteration 0) and records the result strobe until the sequencer returns to idle.
   task automatic run_meas(input int pre, input int dly, input int wid,
                           input int req_at, input int auto_off_at);
      int budget;
      budget = 0;
      while (s1_trig !== 1'b1 && budget < 100) begin
         @(negedge clk_1m);
         budget++;
      end
      if (pre > 0) s1_echo = 1'b1;
      r_trig_w = 0;
      while (s1_trig === 1'b1 && r_trig_w < 200) begin
         r_trig_w++;
         @(negedge clk_1m);
      end
      r_n_vld  = 0;
      r_t_vld  = -1;
      r_t_idle = -1;
      r_cm     = 10'd0;
      r_us     = 16'd0;
      r_err    = 1'b0;
      for (int t = 0; t < 8000; t++) begin
         if (dist_vld === 1'b1) begin
            r_n_vld++;
            if (r_t_vld < 0) begin
               r_t_vld = t;
               r_cm    = dist_cm;
               r_us    = echo_us;
               r_err   = dist_err;
            end
         end
         if (busy === 1'b0) begin
            r_t_idle = t;
            break;
         end
         s1_echo  = (t < pre) || (t >= dly && t < dly + wid);
         meas_req = (t == req_at);
         if (t == auto_off_at) auto_en = 1'b0;
         @(negedge clk_1m);
      end
      s1_echo  = 1'b0;
      meas_req = 1'b0;
   endtask

   task automatic check_ok(input string tag, input int dly, input int wid);
      logic [9:0] exp_cm;
      exp_cm = model_cm(wid);
      chk({tag, "_trig_w"}, 32'(r_trig_w), 32'(TRIG));
      chk({tag, "_n_vld"}, 32'(r_n_vld), 32'd1);
      chk({tag, "_t_vld"}, 32'(r_t_vld), 32'(dly + wid + 3));
      chk({tag, "_err"}, 32'(r_err), 32'd0);
      chk({tag, "_cm"}, 32'(r_cm), 32'(exp_cm));
      chk_rng({tag, "_us"}, int'(r_us), wid - 1, wid + 1);
      chk({tag, "_t_idle"}, 32'(r_t_idle), 32'(r_t_vld + HOLD));
   endtask

   task automatic check_err(input string tag, input int tv_lo, input int tv_hi, input int t_idle);
      chk({tag, "_trig_w"}, 32'(r_trig_w), 32'(TRIG));
      chk({tag, "_n_vld"}, 32'(r_n_vld), 32'd1);
      chk_rng({tag, "_t_vld"}, r_t_vld, tv_lo, tv_hi);
      chk({tag, "_err"}, 32'(r_err), 32'd1);
      chk({tag, "_cm"}, 32'(r_cm), 32'd1023);
      chk({tag, "_us"}, 32'(r_us), 32'hFFFF);
      chk({tag, "_t_idle"}, 32'(r_t_idle), 32'(t_idle));
   endtask

   task automatic quiet(input string tag, input int n);
      int hits;
      hits = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk_1m);
         if (s1_trig !== 1'b0 || dist_vld !== 1'b0 || busy !== 1'b0) hits++;
      end
      chk({tag, "_quiet"}, 32'(hits), 32'd0);
   endtask

   initial begin
      int dly;
      int wid;
      int widths[4];
      widths = '{1160, 1160, 1160, 2320};

      repeat (3) @(negedge clk_1m);
      chk("rst_trig", 32'(s1_trig), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cm", 32'(dist_cm), 32'd0);
      chk("rst_us", 32'(echo_us), 32'd0);
      chk("rst_vld", 32'(dist_vld), 32'd0);
      chk("rst_err", 32'(dist_err), 32'd0);
      rst_n = 1'b1;
      quiet("idle_after_rst", 20);

      pulse_req("m580");
      run_meas(0, 50, 580, -1, -1);
      check_ok("m580", 50, 580);

      pulse_req("noecho");
      run_meas(0, 100000, 0, -1, -1);
      check_err("noecho", ECHO_TO, ECHO_TO, ECHO_TO + HOLD);

      pulse_req("held");
      run_meas(0, 20, 3000, -1, -1);
      check_err("held", 20 + MEAS_MAX + 2, 20 + MEAS_MAX + 4, 20 + 3000 + 3);

      pulse_req("prehigh");
      run_meas(20, 50, 116, -1, -1);
      check_ok("prehigh", 50, 116);

      pulse_req("req_in_meas");
      run_meas(0, 30, 800, 300, -1);
      check_ok("req_in_meas", 30, 800);
      quiet("no_queued_req", 50);

      pulse_req("rst_meas");
      while (s1_trig === 1'b1) @(negedge clk_1m);
      s1_echo = 1'b1;
      repeat (100) @(negedge clk_1m);
      rst_n = 1'b0;
      #1;
      chk("rst_meas_trig", 32'(s1_trig), 32'd0);
      chk("rst_meas_busy", 32'(busy), 32'd0);
      chk("rst_meas_cm", 32'(dist_cm), 32'd0);
      chk("rst_meas_us", 32'(echo_us), 32'd0);
      chk("rst_meas_vld", 32'(dist_vld), 32'd0);
      chk("rst_meas_err", 32'(dist_err), 32'd0);
      hist_q.delete();
      @(negedge clk_1m);
      s1_echo = 1'b0;
      rst_n   = 1'b1;
      quiet("after_rst_meas", 300);

      pulse_req("rst_trig");
      rst_n = 1'b0;
      #1;
      chk("rst_trig_async", 32'(s1_trig), 32'd0);
      chk("rst_trig_busy", 32'(busy), 32'd0);
      @(negedge clk_1m);
      rst_n = 1'b1;
      quiet("after_rst_trig", 30);

      auto_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         run_meas(0, 40, widths[k], -1, (k == 3) ? 100 : -1);
         check_ok($sformatf("auto%0d", k), 40, widths[k]);
      end
      quiet("auto_off", 100);

      for (int k = 0; k < 8; k++) begin
         dly = int'($urandom_range(1, 250));
         wid = int'($urandom_range(1, 2400));
         pulse_req($sformatf("rnd%0d", k));
         run_meas(0, dly, wid, -1, -1);
         check_ok($sformatf("rnd%0d", k), dly, wid);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
